// File: rtl/graph_colour_bank.sv
// graph_colour_bank
//   Double-buffered bank of NUM_CH colour registers behind an Avalon-MM slave.
//   Software writes SHADOW registers, then requests a commit through CTRL.
//   The commit copies every SHADOW into its ACTIVE register on one edge,
//   either straight away (SYNC_EN=0) or at the next frame_sync (SYNC_EN=1).
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   address      Avalon word address (ADDR_W bits)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    32-bit write data
//   frame_sync   single-cycle frame boundary strobe
//   readdata     32-bit read data, combinational from address
//   out_port     ACTIVE colours, channel i at [i*DATA_W +: DATA_W]
//   commit_done  one-cycle pulse in the cycle after ACTIVE was loaded
//
// Register map (word addresses)
//   0 .. NUM_CH-1            SHADOW[i]  RW
//   NUM_CH                   CTRL       RW  bit1 SYNC_EN, bit0 COMMIT (W1 request, reads 0)
//   NUM_CH+1                 STATUS     RO  bit0 pending, bit1 SYNC_EN, [15:8] commit_count
//   NUM_CH+2 .. 2*NUM_CH+1   ACTIVE[i]  RO
module graph_colour_bank #(
  parameter int                 NUM_CH    = 4,
  parameter int                 DATA_W    = 24,
  parameter int                 ADDR_W    = 4,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  input  logic                      frame_sync,
  output logic [31:0]               readdata,
  output logic [NUM_CH*DATA_W-1:0]  out_port,
  output logic                      commit_done
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_CH + 1);

  logic [DATA_W-1:0] shadow_reg [NUM_CH];
  logic [DATA_W-1:0] active_reg [NUM_CH];
  logic              sync_en_reg;
  logic              pending_reg;
  logic              pending_next;
  logic [7:0]        commit_count_reg;
  logic [7:0]        commit_count_next;
  logic              commit_done_reg;

  logic              wr_en;
  logic              ctrl_we;
  logic              commit_req;
  logic              transfer;
  logic [NUM_CH-1:0] shadow_sel;
  logic [NUM_CH-1:0] active_sel;
  logic [NUM_CH-1:0] shadow_we;

  // Only the low DATA_W bits (and CTRL bits 1:0) carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en      = chipselect & ~write_n;
  assign ctrl_we    = wr_en && (address == CTRL_ADDR);
  assign commit_req = ctrl_we && writedata[0];

  // Decided purely on the state held at the start of the cycle, so a CTRL
  // write in this cycle cannot influence whether a transfer happens now.
  assign transfer = pending_reg & (~sync_en_reg | frame_sync);

  // Per-channel address decode and output packing.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [ADDR_W-1:0] SH_ADDR = ADDR_W'(gi);
      localparam logic [ADDR_W-1:0] AC_ADDR = ADDR_W'(NUM_CH + 2 + gi);

      assign shadow_sel[gi] = (address == SH_ADDR);
      assign active_sel[gi] = (address == AC_ADDR);
      assign shadow_we[gi]  = wr_en & shadow_sel[gi];
      assign out_port[gi*DATA_W +: DATA_W] = active_reg[gi];
    end
  endgenerate

  // A new request wins over the clear from a simultaneous transfer: the
  // request may follow shadow writes the transfer did not capture.
  always_comb begin
    pending_next      = pending_reg;
    commit_count_next = commit_count_reg;
    if (transfer) begin
      pending_next      = 1'b0;
      commit_count_next = commit_count_reg + 8'd1;
    end
    if (commit_req) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_reg[i] <= RESET_VAL;
        active_reg[i] <= RESET_VAL;
      end
      sync_en_reg      <= 1'b0;
      pending_reg      <= 1'b0;
      commit_count_reg <= 8'd0;
      commit_done_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // ACTIVE samples the pre-edge SHADOW, so a shadow write on the
        // transfer edge stays in SHADOW for the next commit.
        if (transfer) begin
          active_reg[i] <= shadow_reg[i];
        end
        if (shadow_we[i]) begin
          shadow_reg[i] <= writedata[DATA_W-1:0];
        end
      end
      if (ctrl_we) begin
        sync_en_reg <= writedata[1];
      end
      pending_reg      <= pending_next;
      commit_count_reg <= commit_count_next;
      commit_done_reg  <= transfer;
    end
  end

  assign commit_done = commit_done_reg;

  // Zero-wait-state read mux; unmapped addresses fall through to zero.
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (shadow_sel[i]) begin
        readdata = 32'(shadow_reg[i]);
      end
      if (active_sel[i]) begin
        readdata = 32'(active_reg[i]);
      end
    end
    if (address == CTRL_ADDR) begin
      readdata = {30'b0, sync_en_reg, 1'b0};
    end
    if (address == STATUS_ADDR) begin
      readdata = {16'b0, commit_count_reg, 6'b0, sync_en_reg, pending_reg};
    end
  end

endmodule

// File: tb/tb_graph_colour_bank.sv
// Directed bench for graph_colour_bank. A bench-side model of SHADOW/ACTIVE
// predicts the out_port value at each commit request (pushed to a queue);
// the value is popped and compared when commit_done is observed.
module tb_graph_colour_bank;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int OUT_W  = NUM_CH * DATA_W;
  localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(NUM_CH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic              frame_sync;
  logic [31:0]       readdata;
  logic [OUT_W-1:0]  out_port;
  logic              commit_done;

  graph_colour_bank #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RESET_VAL('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .frame_sync (frame_sync),
    .readdata   (readdata),
    .out_port   (out_port),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] sh_m  [NUM_CH];
  logic [DATA_W-1:0] act_m [NUM_CH];
  bit                sync_m;
  bit                pend_m;
  logic [7:0]        cnt_m;
  logic [OUT_W-1:0]  exp_q [$];

  function automatic logic [OUT_W-1:0] pack_shadow();
    logic [OUT_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = sh_m[i];
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] pack_active();
    logic [OUT_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = act_m[i];
    return v;
  endfunction

  function automatic logic [31:0] status_exp();
    return {16'b0, cnt_m, 6'b0, sync_m, pend_m};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      sh_m[i]  = '0;
      act_m[i] = '0;
    end
    sync_m = 1'b0;
    pend_m = 1'b0;
    cnt_m  = 8'd0;
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit fs);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    frame_sync = fs;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    frame_sync = 1'b0;
    $display("write addr=%0d data=0x%08h frame_sync=%0d", a, d, fs);
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
    $display("read  addr=%0d data=0x%08h", a, d);
  endtask

  task automatic check_read(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic shadow_write(input int i, input logic [31:0] d, input bit fs);
    bus_write(ADDR_W'(i), d, fs);
    sh_m[i] = d[DATA_W-1:0];
  endtask

  task automatic ctrl_write(input logic [31:0] d, input bit fs);
    bus_write(CTRL_A, d, fs);
    sync_m = d[1];
    if (d[0] && !pend_m) begin
      pend_m = 1'b1;
      exp_q.push_back(pack_shadow());
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_sync = 1'b1;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
    $display("frame_sync pulse");
  endtask

  // Called just after the edge on which the transfer is expected.
  task automatic expect_commit(input string tag);
    logic [OUT_W-1:0] e;
    e = pack_active();
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_done"}, commit_done, 1'b1);
    check({tag, "_out"}, out_port, e);
    for (int i = 0; i < NUM_CH; i++) act_m[i] = e[i*DATA_W +: DATA_W];
    pend_m = 1'b0;
    cnt_m  = cnt_m + 8'd1;
    $display("commit %s out_port=0x%0h", tag, out_port);
    idle(1);
    check({tag, "_pulse_end"}, commit_done, 1'b0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      idle(1);
      check({tag, "_no_done"}, commit_done, 1'b0);
      check({tag, "_out_hold"}, out_port, pack_active());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    frame_sync = 1'b0;
    model_reset();
    idle(3);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_out", out_port, '0);
    check("rst_done", commit_done, 1'b0);
    check_read("rst_status", STATUS_A, 32'h0);
    check_read("rst_ctrl", CTRL_A, 32'h0);
    check_read("rst_shadow0", 4'd0, 32'h0);

    // Immediate commit, upper write bits dropped, exact latency
    shadow_write(0, 32'h00FF8040, 1'b0);
    shadow_write(1, 32'hAB123456, 1'b0);
    check("shadow_no_effect", out_port, '0);
    check_read("shadow1_trunc", 4'd1, 32'h00123456);
    ctrl_write(32'h1, 1'b0);
    check("async_lat_done", commit_done, 1'b0);
    check("async_lat_out", out_port, '0);
    idle(1);
    expect_commit("async");
    check_read("async_status", STATUS_A, 32'h00000100);
    check_read("active0_rd", 4'd6, 32'h00FF8040);

    // Frame-synchronised commit
    ctrl_write(32'h2, 1'b0);
    check_read("ctrl_rd_sync", CTRL_A, 32'h2);
    shadow_write(2, 32'h00123456, 1'b0);
    ctrl_write(32'h3, 1'b0);
    check_read("ctrl_rd_nocommit", CTRL_A, 32'h2);
    check_read("sync_pending", STATUS_A, status_exp());
    expect_quiet("sync_wait", 10);
    pulse_frame();
    expect_commit("sync");
    check_read("sync_status", STATUS_A, status_exp());
    check_read("active2_rd", 4'd8, 32'h00123456);

    // Shadow write on the transfer edge
    ctrl_write(32'h3, 1'b0);
    shadow_write(1, 32'h00AAAAAA, 1'b1);
    expect_commit("same_edge");
    check_read("same_edge_shadow1", 4'd1, 32'h00AAAAAA);
    check_read("same_edge_active1", 4'd7, 32'h00123456);

    // Commit written during frame_sync only arms pending
    ctrl_write(32'h3, 1'b1);
    expect_quiet("commit_in_frame", 3);
    pulse_frame();
    expect_commit("late_frame");

    // frame_sync with nothing pending
    pulse_frame();
    expect_quiet("idle_frame", 2);

    // Clearing SYNC_EN releases the pending transfer
    shadow_write(3, 32'h000F0F0F, 1'b0);
    ctrl_write(32'h3, 1'b0);
    expect_quiet("sync_hold", 2);
    ctrl_write(32'h0, 1'b0);
    check("sync_clear_lat", commit_done, 1'b0);
    idle(1);
    expect_commit("sync_clear");

    // Repeated requests collapse into one transfer
    ctrl_write(32'h2, 1'b0);
    ctrl_write(32'h3, 1'b0);
    ctrl_write(32'h3, 1'b0);
    ctrl_write(32'h3, 1'b0);
    expect_quiet("multi_req", 2);
    pulse_frame();
    expect_commit("multi_req");
    expect_quiet("multi_single", 3);
    check_read("multi_count", STATUS_A, status_exp());

    // Run the commit counter round to wrap
    ctrl_write(32'h0, 1'b0);
    do begin
      bus_write(CTRL_A, 32'h1, 1'b0);
      idle(1);
      cnt_m = cnt_m + 8'd1;
      for (int i = 0; i < NUM_CH; i++) act_m[i] = sh_m[i];
    end while (cnt_m != 8'd0);
    check_read("count_wrap", STATUS_A, 32'h0);

    // Unmapped and read-only addresses
    check_read("unmapped10", 4'd10, 32'h0);
    check_read("unmapped15", 4'd15, 32'h0);
    bus_write(4'd10, 32'hFFFFFFFF, 1'b0);
    bus_write(STATUS_A, 32'hFFFFFFFF, 1'b0);
    bus_write(4'd6, 32'hFFFFFFFF, 1'b0);
    bus_write(4'd15, 32'hFFFFFFFF, 1'b0);
    expect_quiet("ro_write", 2);
    check_read("ro_shadow0", 4'd0, 32'(sh_m[0]));
    check_read("ro_active0", 4'd6, 32'(act_m[0]));
    check_read("ro_status", STATUS_A, status_exp());
    check_read("ro_ctrl", CTRL_A, 32'h0);
    check_read("ro_unmapped10", 4'd10, 32'h0);

    // Reset discards a pending frame-synchronised transfer
    ctrl_write(32'h2, 1'b0);
    ctrl_write(32'h3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    $display("reset pulse");
    check("rst2_out", out_port, '0);
    check("rst2_done", commit_done, 1'b0);
    check_read("rst2_status", STATUS_A, 32'h0);
    check_read("rst2_shadow2", 4'd2, 32'h0);
    pulse_frame();
    check("rst2_frame_done", commit_done, 1'b0);
    expect_quiet("rst2_after", 3);
    check_read("rst2_ctrl", CTRL_A, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
